// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers for gray_counter and its downstream
// gray_to_binary consumer. Helpers work on a 16-bit container (the widest
// legal counter) and take the active width so callers can size-cast results.
package gray_pkg;

  // Widest counter the helpers support.
  localparam int GRAY_MAX_WIDTH = 16;

  // Width of the default build, matching the 4-bit gray_to_binary downstream.
  localparam int GRAY_WIDTH = 4;

  // Largest binary count of the default build (the last code before wrap).
  localparam logic [GRAY_MAX_WIDTH-1:0] GRAY_MAX_BIN =
    GRAY_MAX_WIDTH'((1 << GRAY_WIDTH) - 1);

  // Binary to reflected Gray: each bit is the XOR of itself and the next
  // higher binary bit. Bits above the active width are forced to zero.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
    input logic [GRAY_MAX_WIDTH-1:0] bin,
    input int                        width
  );
    logic [GRAY_MAX_WIDTH-1:0] masked;
    masked = '0;
    for (int i = 0; i < GRAY_MAX_WIDTH; i++) begin
      if (i < width) begin
        masked[i] = bin[i];
      end
    end
    return masked ^ (masked >> 1);
  endfunction

  // Gray to binary as a prefix XOR running from the MSB downwards; this is
  // the same bit order gray_to_binary uses, so both agree bit-for-bit.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
    input logic [GRAY_MAX_WIDTH-1:0] gray,
    input int                        width
  );
    logic [GRAY_MAX_WIDTH-1:0] bin;
    logic                      acc;
    bin = '0;
    acc = 1'b0;
    for (int i = GRAY_MAX_WIDTH - 1; i >= 0; i--) begin
      if (i < width) begin
        acc    = acc ^ gray[i];
        bin[i] = acc;
      end
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_counter.sv
// gray_counter: synchronous up/down Gray-code generator with synchronous
// load, a one-cycle wrap pulse and a valid/ready output handshake.
// Optional build macro GRAY_COUNTER_SATURATE_EN: steps at either end of the
// range hold the count and pulse wrap as a "limit hit" flag instead of
// rolling over.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_BIN = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_BIN = WIDTH'(1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_outValid;
  logic             r_wrap;

  logic             w_accept;
  logic             w_step;
  logic             w_atLimit;
  logic [WIDTH-1:0] w_binStep;
  logic [WIDTH-1:0] w_stepBin;
  logic [WIDTH-1:0] w_stepGray;
  logic [WIDTH-1:0] w_loadBin;

  // A code is consumed only when it is both offered and taken; load wins
  // over stepping, and en only gates the count, never the handshake.
  assign w_accept = r_outValid & out_ready;
  assign w_step   = w_accept & en & ~load;

  // Next-state arithmetic: the candidate count for a step, whether that step
  // crosses an end of the sequence, and the matching Gray code.
  always_comb begin
    w_atLimit = up ? (r_bin == MAX_BIN) : (r_bin == '0);
    w_binStep = up ? (r_bin + ONE_BIN) : (r_bin - ONE_BIN);
`ifdef GRAY_COUNTER_SATURATE_EN
    w_stepBin = w_atLimit ? r_bin : w_binStep;
`else
    w_stepBin = w_binStep;
`endif
    w_stepGray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(w_stepBin), WIDTH));
    w_loadBin  = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(load_gray), WIDTH));
  end

  // State register: reset beats load, load beats step, otherwise hold; the
  // Gray output is registered so no input reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin      <= '0;
      r_gray     <= '0;
      r_outValid <= 1'b0;
      r_wrap     <= 1'b0;
    end else if (load) begin
      r_bin      <= w_loadBin;
      r_gray     <= load_gray;
      r_outValid <= 1'b1;
      r_wrap     <= 1'b0;
    end else if (w_step) begin
      r_bin      <= w_stepBin;
      r_gray     <= w_stepGray;
      r_outValid <= 1'b1;
      r_wrap     <= w_atLimit;
    end else begin
      r_outValid <= 1'b1;
      r_wrap     <= 1'b0;
    end
  end

  assign gray      = r_gray;
  assign out_valid = r_outValid;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed test-plan sequences followed by randomized
// traffic, all checked against an integer-count reference model.
module tb_gray_counter;

  localparam int W    = 4;
  localparam int MAXB = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_gray;
  logic [W-1:0] gray;
  logic         out_valid;
  logic         out_ready;
  logic         wrap;

  int vectorCount = 0;
  int missCount   = 0;

  // Reference model state: position in the sequence, valid flag, wrap flag.
  int mCnt   = 0;
  bit mValid = 1'b0;
  bit mWrap  = 1'b0;
  int mPrevCnt = 0;

  int upCodes[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  gray_counter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_gray (load_gray),
    .gray      (gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wrap      (wrap)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reflected Gray code of sequence position n.
  function automatic int codeOf(input int n);
    return n ^ (n >> 1);
  endfunction

  // Sequence position of a Gray code, found by searching the sequence.
  function automatic int positionOf(input int g);
    for (int n = 0; n <= MAXB; n++) begin
      if (codeOf(n) == g) return n;
    end
    return -1;
  endfunction

  // Advance the reference model by one clock edge with the given inputs.
  task automatic modelEdge(input bit iRst, input bit iEn, input bit iUp,
                           input bit iLoad, input int iLg, input bit iReady);
    mPrevCnt = mCnt;
    if (iRst) begin
      mCnt = 0; mValid = 1'b0; mWrap = 1'b0;
    end else if (iLoad) begin
      mCnt = positionOf(iLg); mValid = 1'b1; mWrap = 1'b0;
    end else if (mValid && iReady && iEn) begin
      mWrap = 1'b0;
      if (iUp) begin
        if (mCnt == MAXB) begin
          mWrap = 1'b1;
`ifndef GRAY_COUNTER_SATURATE_EN
          mCnt = 0;
`endif
        end else mCnt = mCnt + 1;
      end else begin
        if (mCnt == 0) begin
          mWrap = 1'b1;
`ifndef GRAY_COUNTER_SATURATE_EN
          mCnt = MAXB;
`endif
        end else mCnt = mCnt - 1;
      end
      mValid = 1'b1;
    end else begin
      mWrap = 1'b0; mValid = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, take the edge, update the model, settle.
  task automatic applyStimulus(input bit iRst, input bit iEn, input bit iUp,
                               input bit iLoad, input int iLg, input bit iReady);
    rst = iRst; en = iEn; up = iUp; load = iLoad;
    load_gray = W'(iLg); out_ready = iReady;
    @(posedge clk);
    modelEdge(iRst, iEn, iUp, iLoad, iLg, iReady);
    #1;
  endtask

  // Compare all outputs against the model.
  task automatic checkModel(input string tag);
    checkOutput({tag, ".gray"}, 32'(gray), 32'(codeOf(mCnt)));
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'(mValid));
    checkOutput({tag, ".wrap"}, 32'(wrap), 32'(mWrap));
  endtask

  logic [W-1:0] prevGray;

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_gray = '0; out_ready = 1'b0;

    // Reset state.
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkModel("reset");
    checkOutput("reset.validLow", 32'(out_valid), 32'd0);

    // Full up sequence: first cycle only raises valid, then one code per cycle.
    applyStimulus(0, 1, 1, 0, 0, 1);
    checkModel("release");
    checkOutput("upseq0", 32'(gray), 32'(upCodes[0]));
    for (int i = 1; i < 16; i++) begin
      prevGray = gray;
      applyStimulus(0, 1, 1, 0, 0, 1);
      checkModel("upseq");
      checkOutput("upseq.code", 32'(gray), 32'(upCodes[i]));
      checkOutput("upseq.onebit", 32'($countones(prevGray ^ gray)), 32'd1);
    end
    prevGray = gray;
    applyStimulus(0, 1, 1, 0, 0, 1);
    checkModel("upwrap");
    checkOutput("upwrap.code", 32'(gray), 32'd0);
    checkOutput("upwrap.pulse", 32'(wrap), 32'd1);
    checkOutput("upwrap.onebit", 32'($countones(prevGray ^ gray)), 32'd1);

    // Step on to 0110, then stall for five cycles.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 1, 0, 0, 1);
      checkModel("toSix");
    end
    checkOutput("toSix.code", 32'(gray), 32'd6);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 1, 0, 0, 0);
      checkModel("hold");
      checkOutput("hold.code", 32'(gray), 32'd6);
    end
    applyStimulus(0, 1, 1, 0, 0, 1);
    checkModel("afterHold");
    checkOutput("afterHold.code", 32'(gray), 32'd7);

    // Accept with en low: code is presented again unchanged.
    applyStimulus(0, 0, 1, 0, 0, 1);
    checkModel("disabled");
    checkOutput("disabled.code", 32'(gray), 32'd7);

    // Load 1011 while stalled, then one step down.
    applyStimulus(0, 1, 0, 1, 11, 0);
    checkModel("load");
    checkOutput("load.code", 32'(gray), 32'd11);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkModel("loadDown");
    checkOutput("loadDown.code", 32'(gray), 32'd10);

    // Down count from reset wraps to 1000, then continues to 1001.
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkModel("downRelease");
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkModel("downWrap");
    checkOutput("downWrap.code", 32'(gray), 32'd8);
    checkOutput("downWrap.pulse", 32'(wrap), 32'd1);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkModel("downNext");
    checkOutput("downNext.code", 32'(gray), 32'd9);

    // Reset together with load mid-count discards everything.
    applyStimulus(0, 1, 1, 1, 13, 1);
    checkOutput("preReset.code", 32'(gray), 32'd13);
    applyStimulus(1, 1, 1, 1, 5, 1);
    checkModel("resetLoad");
    checkOutput("resetLoad.code", 32'(gray), 32'd0);
    checkOutput("resetLoad.valid", 32'(out_valid), 32'd0);
    applyStimulus(0, 1, 1, 0, 0, 1);
    checkModel("resetLoadRelease");
    checkOutput("resetLoadRelease.valid", 32'(out_valid), 32'd1);

    // Limit behaviour at the top of the range.
    applyStimulus(0, 1, 1, 1, 8, 1);
    applyStimulus(0, 1, 1, 0, 0, 1);
    checkModel("limitUp");
`ifdef GRAY_COUNTER_SATURATE_EN
    checkOutput("limitUp.code", 32'(gray), 32'd8);
`else
    checkOutput("limitUp.code", 32'(gray), 32'd0);
`endif
    checkOutput("limitUp.pulse", 32'(wrap), 32'd1);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkModel("limitDown");
`ifdef GRAY_COUNTER_SATURATE_EN
    checkOutput("limitDown.code", 32'(gray), 32'd9);
`else
    checkOutput("limitDown.code", 32'(gray), 32'd8);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit rRst, rEn, rUp, rLoad, rReady;
      int rLg;
      rRst   = ($urandom_range(0, 39) == 0);
      rLoad  = ($urandom_range(0, 9) == 0);
      rEn    = ($urandom_range(0, 4) != 0);
      rUp    = $urandom_range(0, 1) != 0;
      rReady = ($urandom_range(0, 3) != 0);
      rLg    = $urandom_range(0, MAXB);
      prevGray = gray;
      applyStimulus(rRst, rEn, rUp, rLoad, rLg, rReady);
      checkModel("random");
      if (!rRst && !rLoad) begin
        checkOutput("random.onebit", 32'($countones(prevGray ^ gray)),
                    32'((mPrevCnt != mCnt) ? 1 : 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
